// File: rtl/crc_code_arbiter_controller.sv
// Sequencer for a CRC shift datapath shared between a write (encode) and a read (decode)
// channel: latches requests, arbitrates, runs LOAD/SHIFT/DONE and reports drops.
module crc_code_arbiter_controller #(
    parameter int unsigned SHIFT_CYCLES = 32,
    parameter int unsigned CRC_WIDTH    = 8,
    parameter int unsigned ARB_MODE     = 0,
    localparam int unsigned TOTAL       = SHIFT_CYCLES + CRC_WIDTH,
    localparam int unsigned CNT_W       = $clog2(TOTAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic             read,
    input  logic             abort,
    output logic             load_en,
    output logic             shift_en,
    output logic             aug_en,
    output logic             sel_write,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             write_mem_en,
    output logic             write_mem_busy,
    output logic             read_data_valid,
    output logic             read_controller_busy,
    output logic             drop_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CntAug  = CNT_W'(SHIFT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_w_q, pend_w_d;
    logic             pend_r_q, pend_r_d;
    logic             sel_q, sel_d;
    logic             last_w_q, last_w_d;
    logic             drop_q, drop_d;

    logic active;
    logic acc_w, acc_r;
    logic cand_w, cand_r;
    logic grant_w;

    always_comb begin
        active = (state_q == StLoad) || (state_q == StShift);
        // A channel in its own DONE cycle may re-request; only LOAD/SHIFT ownership drops it.
        acc_w  = write & ~pend_w_q & ~(active & sel_q);
        acc_r  = read & ~pend_r_q & ~(active & ~sel_q);
        drop_d = (write & ~acc_w) | (read & ~acc_r);
        cand_w = pend_w_q | acc_w;
        cand_r = pend_r_q | acc_r;

        if (cand_w && cand_r) begin
            if (ARB_MODE == 1) begin
                grant_w = 1'b1;
            end else if (ARB_MODE == 2) begin
                grant_w = 1'b0;
            end else begin
                grant_w = ~last_w_q;
            end
        end else begin
            grant_w = cand_w;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        sel_d    = sel_q;
        last_w_d = last_w_q;
        pend_w_d = cand_w;
        pend_r_d = cand_r;

        unique case (state_q)
            StIdle, StDone: begin
                if (cand_w || cand_r) begin
                    state_d  = StLoad;
                    sel_d    = grant_w;
                    last_w_d = grant_w;
                    if (grant_w) begin
                        pend_w_d = 1'b0;
                    end else begin
                        pend_r_d = 1'b0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                state_d = abort ? StIdle : StShift;
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pend_w_q <= 1'b0;
            pend_r_q <= 1'b0;
            sel_q    <= 1'b0;
            last_w_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_w_q <= pend_w_d;
            pend_r_q <= pend_r_d;
            sel_q    <= sel_d;
            last_w_q <= last_w_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        load_en              = (state_q == StLoad);
        shift_en             = (state_q == StShift);
        aug_en               = shift_en & sel_q & (cnt_q >= CntAug);
        sel_write            = sel_q;
        bit_cnt              = cnt_q;
        write_mem_en         = (state_q == StDone) & sel_q;
        read_data_valid      = (state_q == StDone) & ~sel_q;
        write_mem_busy       = pend_w_q | ((state_q != StIdle) & sel_q);
        read_controller_busy = pend_r_q | ((state_q != StIdle) & ~sel_q);
        drop_err             = drop_q;
    end

endmodule
